// File: rtl/redun_mont_seq.sv
// Job sequencer for the redun_mont repeated-squaring core: accepts a job, resets and loads
// the core, counts T result pulses and returns the final value with a status code.
module redun_mont_seq #(
  parameter int ITER_W      = 32,
  parameter int RST_CYC     = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int SQ_W        = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start_val,
  output logic              o_start_rdy,
  input  logic [SQ_W-1:0]   i_start_sq,
  input  logic [ITER_W-1:0] i_start_iters,
  input  logic              i_abort,
  output logic              o_res_val,
  input  logic              i_res_rdy,
  output logic [SQ_W-1:0]   o_res_sq,
  output logic [ITER_W-1:0] o_res_iters,
  output logic [1:0]        o_res_status,
  output logic              o_busy,
  output logic              o_core_rst,
  output logic [SQ_W-1:0]   o_core_sq,
  output logic              o_core_val,
  input  logic [SQ_W-1:0]   i_core_mul,
  input  logic              i_core_val
);

  localparam int CLR_W = $clog2(RST_CYC + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_ABORT   = 2'd2;

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    CLR  = 5'b00010,
    LOAD = 5'b00100,
    RUN  = 5'b01000,
    DONE = 5'b10000
  } state_t;

  state_t            state, state_next;
  logic [ITER_W-1:0] iters_target;
  logic [ITER_W-1:0] done_cnt;
  logic [ITER_W-1:0] done_cnt_inc;
  logic [CLR_W-1:0]  clr_cnt;
  logic [WD_W-1:0]   wd_cnt;
  logic [1:0]        status_next;
  logic              accept;
  logic              active;
  logic              pulse;
  logic              reach;
  logic              timeout;

  // Abort is applied last so it overrides a final pulse or timeout in the same cycle.
  always_comb begin
    state_next   = state;
    status_next  = o_res_status;
    accept       = (state == IDLE) && i_start_val;
    active       = (state == CLR) || (state == LOAD) || (state == RUN);
    pulse        = (state == RUN) && i_core_val;
    done_cnt_inc = (done_cnt == '1) ? done_cnt : done_cnt + 1'b1;
    reach        = pulse && (done_cnt_inc == iters_target);
    timeout      = (state == RUN) && !i_core_val && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next  = (i_start_iters == '0) ? DONE : CLR;
          status_next = ST_OK;
        end
      end
      CLR:  if (clr_cnt == CLR_W'(RST_CYC - 1)) state_next = LOAD;
      LOAD: state_next = RUN;
      RUN: begin
        if (reach) begin
          state_next  = DONE;
          status_next = ST_OK;
        end else if (timeout) begin
          state_next  = DONE;
          status_next = ST_TIMEOUT;
        end
      end
      DONE: if (i_res_rdy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (active && i_abort) begin
      state_next  = DONE;
      status_next = ST_ABORT;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Handshake and core-control outputs are registered from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_start_rdy  <= 1'b1;
      o_res_val    <= 1'b0;
      o_core_val   <= 1'b0;
      o_core_rst   <= 1'b1;
      o_busy       <= 1'b0;
      o_res_status <= ST_OK;
      iters_target <= '0;
      done_cnt     <= '0;
      clr_cnt      <= '0;
      wd_cnt       <= '0;
    end else begin
      o_start_rdy  <= (state_next == IDLE);
      o_busy       <= (state_next != IDLE);
      o_res_val    <= (state_next == DONE);
      o_core_val   <= (state_next == LOAD);
      o_core_rst   <= (state_next == IDLE) || (state_next == CLR) || (state_next == DONE);
      o_res_status <= status_next;
      if (accept) begin
        iters_target <= i_start_iters;
        done_cnt     <= '0;
        clr_cnt      <= '0;
      end
      if (state == CLR) clr_cnt <= clr_cnt + 1'b1;
      if (state == LOAD) wd_cnt <= WD_W'(1);
      if (state == RUN) begin
        if (i_core_val) begin
          done_cnt <= done_cnt_inc;
          wd_cnt   <= WD_W'(1);
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end
    end
  end

  // Data registers carry no reset; the start value doubles as the result until a pulse arrives.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      o_core_sq <= i_start_sq;
      o_res_sq  <= i_start_sq;
    end else if (pulse) begin
      o_res_sq <= i_core_mul;
    end
  end

  assign o_res_iters = done_cnt;

endmodule

// File: tb/tb_redun_mont_seq.sv
// Directed bench for redun_mont_seq; the core is replaced by pulses driven straight from the tasks.
module tb_redun_mont_seq;

  localparam int ITER_W = 16;
  localparam int SQ_W   = 16;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_start_val = 1'b0;
  logic              o_start_rdy;
  logic [SQ_W-1:0]   i_start_sq = '0;
  logic [ITER_W-1:0] i_start_iters = '0;
  logic              i_abort = 1'b0;
  logic              o_res_val;
  logic              i_res_rdy = 1'b0;
  logic [SQ_W-1:0]   o_res_sq;
  logic [ITER_W-1:0] o_res_iters;
  logic [1:0]        o_res_status;
  logic              o_busy;
  logic              o_core_rst;
  logic [SQ_W-1:0]   o_core_sq;
  logic              o_core_val;
  logic [SQ_W-1:0]   i_core_mul = '0;
  logic              i_core_val = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  redun_mont_seq #(
    .ITER_W(ITER_W), .RST_CYC(4), .TIMEOUT_CYC(16), .SQ_W(SQ_W)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_start_val(i_start_val), .o_start_rdy(o_start_rdy),
    .i_start_sq(i_start_sq), .i_start_iters(i_start_iters),
    .i_abort(i_abort),
    .o_res_val(o_res_val), .i_res_rdy(i_res_rdy),
    .o_res_sq(o_res_sq), .o_res_iters(o_res_iters), .o_res_status(o_res_status),
    .o_busy(o_busy), .o_core_rst(o_core_rst), .o_core_sq(o_core_sq), .o_core_val(o_core_val),
    .i_core_mul(i_core_mul), .i_core_val(i_core_val)
  );

  always #5 i_clk = ~i_clk;

  // Inputs change and outputs are observed on the falling edge.
  task automatic cyc();
    @(negedge i_clk);
  endtask

  task automatic issue(input logic [SQ_W-1:0] sq, input logic [ITER_W-1:0] iters);
    i_start_val   = 1'b1;
    i_start_sq    = sq;
    i_start_iters = iters;
    cyc();
    i_start_val = 1'b0;
  endtask

  // Counts views from the first one after acceptance until o_core_val; -1 if it never shows.
  task automatic await_load(output int n);
    n = 1;
    while (!o_core_val && n < 20) begin
      cyc();
      n++;
    end
    if (!o_core_val) n = -1;
  endtask

  task automatic release_result();
    i_res_rdy = 1'b1;
    cyc();
    i_res_rdy = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    cyc();
    cyc();
    total_cnt++; if (o_start_rdy !== 1'b1) $display("[TB] FAIL reset_start_rdy got %0b want 1", o_start_rdy); else pass_cnt++;
    total_cnt++; if (o_res_val !== 1'b0) $display("[TB] FAIL reset_res_val got %0b want 0", o_res_val); else pass_cnt++;
    total_cnt++; if (o_core_val !== 1'b0) $display("[TB] FAIL reset_core_val got %0b want 0", o_core_val); else pass_cnt++;
    total_cnt++; if (o_core_rst !== 1'b1) $display("[TB] FAIL reset_core_rst got %0b want 1", o_core_rst); else pass_cnt++;
    total_cnt++; if (o_busy !== 1'b0) $display("[TB] FAIL reset_busy got %0b want 0", o_busy); else pass_cnt++;
    total_cnt++; if (o_res_status !== 2'd0) $display("[TB] FAIL reset_status got %0d want 0", o_res_status); else pass_cnt++;
    total_cnt++; if (o_res_iters !== 16'd0) $display("[TB] FAIL reset_iters got %0d want 0", o_res_iters); else pass_cnt++;
    i_rst = 1'b0;
    cyc();
  endtask

  task automatic test_zero_iters();
    logic saw_core_val;
    issue(16'd5, 16'd0);
    saw_core_val = o_core_val;
    total_cnt++; if (o_res_val !== 1'b1) $display("[TB] FAIL t0_res_val got %0b want 1", o_res_val); else pass_cnt++;
    total_cnt++; if (o_res_sq !== 16'd5) $display("[TB] FAIL t0_res_sq got %0h want 5", o_res_sq); else pass_cnt++;
    total_cnt++; if (o_res_status !== 2'd0) $display("[TB] FAIL t0_status got %0d want 0", o_res_status); else pass_cnt++;
    total_cnt++; if (o_res_iters !== 16'd0) $display("[TB] FAIL t0_iters got %0d want 0", o_res_iters); else pass_cnt++;
    total_cnt++; if (o_busy !== 1'b1) $display("[TB] FAIL t0_busy got %0b want 1", o_busy); else pass_cnt++;
    release_result();
    saw_core_val = saw_core_val | o_core_val;
    total_cnt++; if (saw_core_val !== 1'b0) $display("[TB] FAIL t0_core_val got %0b want 0", saw_core_val); else pass_cnt++;
    total_cnt++; if (o_res_val !== 1'b0) $display("[TB] FAIL t0_res_val_after got %0b want 0", o_res_val); else pass_cnt++;
    total_cnt++; if (o_start_rdy !== 1'b1) $display("[TB] FAIL t0_start_rdy_after got %0b want 1", o_start_rdy); else pass_cnt++;
  endtask

  task automatic test_run_ok();
    int n;
    issue(16'h1234, 16'd3);
    total_cnt++; if (o_core_rst !== 1'b1) $display("[TB] FAIL ok_core_rst_clr got %0b want 1", o_core_rst); else pass_cnt++;
    await_load(n);
    total_cnt++; if (n != 5) $display("[TB] FAIL ok_load_cycle got %0d want 5", n); else pass_cnt++;
    total_cnt++; if (o_core_rst !== 1'b0) $display("[TB] FAIL ok_core_rst_load got %0b want 0", o_core_rst); else pass_cnt++;
    total_cnt++; if (o_core_sq !== 16'h1234) $display("[TB] FAIL ok_core_sq got %0h want 1234", o_core_sq); else pass_cnt++;
    cyc();
    total_cnt++; if (o_core_val !== 1'b0) $display("[TB] FAIL ok_core_val_one_cycle got %0b want 0", o_core_val); else pass_cnt++;
    i_core_val = 1'b1; i_core_mul = 16'h1111; cyc();
    i_core_val = 1'b0; cyc();
    i_core_val = 1'b1; i_core_mul = 16'h2222; cyc();
    total_cnt++; if (o_res_val !== 1'b0) $display("[TB] FAIL ok_res_val_early got %0b want 0", o_res_val); else pass_cnt++;
    i_core_mul = 16'h3333; cyc();
    i_core_val = 1'b0;
    total_cnt++; if (o_res_val !== 1'b1) $display("[TB] FAIL ok_res_val got %0b want 1", o_res_val); else pass_cnt++;
    total_cnt++; if (o_res_sq !== 16'h3333) $display("[TB] FAIL ok_res_sq got %0h want 3333", o_res_sq); else pass_cnt++;
    total_cnt++; if (o_res_iters !== 16'd3) $display("[TB] FAIL ok_iters got %0d want 3", o_res_iters); else pass_cnt++;
    total_cnt++; if (o_res_status !== 2'd0) $display("[TB] FAIL ok_status got %0d want 0", o_res_status); else pass_cnt++;
    total_cnt++; if (o_core_rst !== 1'b1) $display("[TB] FAIL ok_core_rst_done got %0b want 1", o_core_rst); else pass_cnt++;
    i_core_val = 1'b1; i_core_mul = 16'hDEAD; cyc();
    i_core_val = 1'b0;
    total_cnt++; if (o_res_sq !== 16'h3333) $display("[TB] FAIL ok_extra_pulse_sq got %0h want 3333", o_res_sq); else pass_cnt++;
    total_cnt++; if (o_res_iters !== 16'd3) $display("[TB] FAIL ok_extra_pulse_iters got %0d want 3", o_res_iters); else pass_cnt++;
    release_result();
  endtask

  task automatic test_timeout();
    int n;
    int k;
    issue(16'h00AB, 16'd5);
    await_load(n);
    total_cnt++; if (n != 5) $display("[TB] FAIL to_load_cycle got %0d want 5", n); else pass_cnt++;
    k = 0;
    while (!o_res_val && k < 40) begin
      cyc();
      k++;
    end
    total_cnt++; if (k != 16) $display("[TB] FAIL to_done_cycle got %0d want 16", k); else pass_cnt++;
    total_cnt++; if (o_res_status !== 2'd1) $display("[TB] FAIL to_status got %0d want 1", o_res_status); else pass_cnt++;
    total_cnt++; if (o_res_iters !== 16'd0) $display("[TB] FAIL to_iters got %0d want 0", o_res_iters); else pass_cnt++;
    total_cnt++; if (o_res_sq !== 16'h00AB) $display("[TB] FAIL to_res_sq got %0h want ab", o_res_sq); else pass_cnt++;
    release_result();
  endtask

  task automatic test_abort();
    int n;
    issue(16'h0BAD, 16'd100);
    await_load(n);
    cyc();
    for (int k = 1; k <= 50; k++) begin
      i_core_val = 1'b1;
      i_core_mul = 16'(k);
      i_abort    = (k == 50);
      cyc();
    end
    i_core_val = 1'b0; i_abort = 1'b0;
    total_cnt++; if (o_res_val !== 1'b1) $display("[TB] FAIL ab_res_val got %0b want 1", o_res_val); else pass_cnt++;
    total_cnt++; if (o_res_status !== 2'd2) $display("[TB] FAIL ab_status got %0d want 2", o_res_status); else pass_cnt++;
    total_cnt++; if (o_res_iters !== 16'd50) $display("[TB] FAIL ab_iters got %0d want 50", o_res_iters); else pass_cnt++;
    release_result();
    issue(16'h0C0C, 16'd2);
    await_load(n);
    cyc();
    i_core_val = 1'b1; i_core_mul = 16'h0001; cyc();
    i_core_mul = 16'h0002; i_abort = 1'b1; cyc();
    i_core_val = 1'b0; i_abort = 1'b0;
    total_cnt++; if (o_res_status !== 2'd2) $display("[TB] FAIL ab_final_status got %0d want 2", o_res_status); else pass_cnt++;
    total_cnt++; if (o_res_iters !== 16'd2) $display("[TB] FAIL ab_final_iters got %0d want 2", o_res_iters); else pass_cnt++;
    release_result();
    i_abort = 1'b1; cyc();
    i_abort = 1'b0;
    total_cnt++; if (o_busy !== 1'b0) $display("[TB] FAIL ab_idle_ignored got busy %0b want 0", o_busy); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int bad;
    issue(16'h0077, 16'd0);
    bad = 0;
    i_start_val = 1'b1; i_start_sq = 16'h0055; i_start_iters = 16'd0;
    for (int k = 0; k < 20; k++) begin
      if (o_res_val !== 1'b1 || o_res_sq !== 16'h0077 || o_res_status !== 2'd0 || o_start_rdy !== 1'b0) bad++;
      cyc();
    end
    i_start_val = 1'b0;
    total_cnt++; if (bad != 0) $display("[TB] FAIL bp_stable got %0d unstable views want 0", bad); else pass_cnt++;
    total_cnt++; if (o_res_sq !== 16'h0077) $display("[TB] FAIL bp_res_sq got %0h want 77", o_res_sq); else pass_cnt++;
    release_result();
    cyc();
    total_cnt++; if (o_busy !== 1'b0) $display("[TB] FAIL bp_no_stray_job got busy %0b want 0", o_busy); else pass_cnt++;
  endtask

  task automatic test_reset_midjob();
    int n;
    issue(16'h0A0A, 16'd10);
    await_load(n);
    cyc();
    i_core_val = 1'b1; i_core_mul = 16'h0F0F; cyc(); cyc();
    i_core_val = 1'b0;
    i_rst = 1'b1; cyc();
    i_rst = 1'b0;
    total_cnt++; if (o_start_rdy !== 1'b1) $display("[TB] FAIL rm_start_rdy got %0b want 1", o_start_rdy); else pass_cnt++;
    total_cnt++; if (o_core_rst !== 1'b1) $display("[TB] FAIL rm_core_rst got %0b want 1", o_core_rst); else pass_cnt++;
    total_cnt++; if (o_res_val !== 1'b0) $display("[TB] FAIL rm_res_val got %0b want 0", o_res_val); else pass_cnt++;
    issue(16'h0042, 16'd2);
    await_load(n);
    total_cnt++; if (n != 5) $display("[TB] FAIL rm_load_cycle got %0d want 5", n); else pass_cnt++;
    cyc();
    i_core_val = 1'b1; i_core_mul = 16'h0101; cyc();
    i_core_mul = 16'h0202; cyc();
    i_core_val = 1'b0;
    total_cnt++; if (o_res_sq !== 16'h0202) $display("[TB] FAIL rm_res_sq got %0h want 202", o_res_sq); else pass_cnt++;
    total_cnt++; if (o_res_iters !== 16'd2) $display("[TB] FAIL rm_iters got %0d want 2", o_res_iters); else pass_cnt++;
    total_cnt++; if (o_res_status !== 2'd0) $display("[TB] FAIL rm_status got %0d want 0", o_res_status); else pass_cnt++;
  endtask

  // Enters with a result pending; a new job is offered during the handshake itself.
  task automatic test_back_to_back();
    i_res_rdy = 1'b1;
    i_start_val = 1'b1; i_start_sq = 16'h0099; i_start_iters = 16'd0;
    cyc();
    total_cnt++; if (o_res_val !== 1'b0) $display("[TB] FAIL bb_res_val_gap got %0b want 0", o_res_val); else pass_cnt++;
    total_cnt++; if (o_start_rdy !== 1'b1) $display("[TB] FAIL bb_start_rdy got %0b want 1", o_start_rdy); else pass_cnt++;
    i_res_rdy = 1'b0;
    cyc();
    i_start_val = 1'b0;
    total_cnt++; if (o_res_val !== 1'b1) $display("[TB] FAIL bb_res_val got %0b want 1", o_res_val); else pass_cnt++;
    total_cnt++; if (o_res_sq !== 16'h0099) $display("[TB] FAIL bb_res_sq got %0h want 99", o_res_sq); else pass_cnt++;
    release_result();
  endtask

  initial begin
    cyc();
    test_reset();
    test_zero_iters();
    test_run_ok();
    test_timeout();
    test_abort();
    test_backpressure();
    test_reset_midjob();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
